// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source round-robin output arbiter.
// Grant encoding doubles as the mux select value.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  function automatic arb_state_e serve_of(input logic g);
    return (g == GNT_B) ? SERVE_B : SERVE_A;
  endfunction

endpackage

// File: rtl/mux_2to1_bus.sv
// Purely combinational DATA_W-wide 2:1 mux.
// sel=0 passes d0, sel=1 passes d1.
module mux_2to1_bus #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_2to1_arb.sv
// Round-robin arbiter sharing one valid/ready stream between A and B,
// with bounded bursts so neither source can starve the other.
module mux_2to1_arb
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  input  logic              y_ready,
  output logic              sel
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          sel_nx;
  logic          last, last_nx;

  logic cur;
  logic x_valid;
  logic o_valid;
  logic beat;

  mux_2to1_bus #(
    .DATA_W(DATA_W)
  ) u_bus (
    .sel(sel),
    .d0 (a_data),
    .d1 (b_data),
    .y  (y_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= GNT_A;
      last  <= GNT_B;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      last  <= last_nx;
    end
  end

  assign cur     = (state == SERVE_B) ? GNT_B : GNT_A;
  assign x_valid = cur ? b_valid : a_valid;
  assign o_valid = cur ? a_valid : b_valid;

  always_comb begin
    y_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      SERVE_A: begin
        y_valid = a_valid;
        a_ready = y_ready;
      end
      SERVE_B: begin
        y_valid = b_valid;
        b_ready = y_ready;
      end
      default: ;
    endcase
  end

  assign beat = (state != IDLE) & x_valid & y_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    last_nx  = last;
    case (state)
      IDLE: begin
        unique case (1'b1)
          a_valid & b_valid: begin
            state_nx = serve_of(~last);
            sel_nx   = ~last;
            last_nx  = ~last;
            cnt_nx   = '0;
          end
          a_valid & ~b_valid: begin
            state_nx = SERVE_A;
            sel_nx   = GNT_A;
            last_nx  = GNT_A;
            cnt_nx   = '0;
          end
          ~a_valid & b_valid: begin
            state_nx = SERVE_B;
            sel_nx   = GNT_B;
            last_nx  = GNT_B;
            cnt_nx   = '0;
          end
          default: ;
        endcase
      end
      SERVE_A, SERVE_B: begin
        if (beat) begin
          if (cnt == LAST_BEAT) begin
            // Burst end: other side first, else a fresh burst here.
            cnt_nx = '0;
            if (o_valid) begin
              state_nx = serve_of(~cur);
              sel_nx   = ~cur;
              last_nx  = ~cur;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (!x_valid) begin
          cnt_nx = '0;
          if (o_valid) begin
            state_nx = serve_of(~cur);
            sel_nx   = ~cur;
            last_nx  = ~cur;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Scoreboard bench for mux_2to1_arb: MAX_BURST=4 and MAX_BURST=1 instances
// share stimulus; dsel picks which one drives the handshake and monitor.
module tb_mux_2to1_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic       y_ready = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic       dsel = 1'b0;

  always #5 clk = ~clk;

  logic       a_ready4, b_ready4, y_valid4, sel4;
  logic [7:0] y_data4;
  logic       a_ready1, b_ready1, y_valid1, sel1;
  logic [7:0] y_data1;

  mux_2to1_arb #(.DATA_W(8), .MAX_BURST(4)) u4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_ready(a_ready4),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ready(b_ready4),
    .y_valid(y_valid4),
    .y_data (y_data4),
    .y_ready(y_ready),
    .sel    (sel4)
  );

  mux_2to1_arb #(.DATA_W(8), .MAX_BURST(1)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_ready(a_ready1),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ready(b_ready1),
    .y_valid(y_valid1),
    .y_data (y_data1),
    .y_ready(y_ready),
    .sel    (sel1)
  );

  logic       ar, br, yv, ys;
  logic [7:0] yd;
  assign ar = dsel ? a_ready1 : a_ready4;
  assign br = dsel ? b_ready1 : b_ready4;
  assign yv = dsel ? y_valid1 : y_valid4;
  assign ys = dsel ? sel1 : sel4;
  assign yd = dsel ? y_data1 : y_data4;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  exp_t       mon_e;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  int b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("both_ready", {31'b0, ar & br}, 32'd0);
      if (yv && y_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", yd);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", {24'b0, yd}, {24'b0, mon_e.data});
          check("beat_sel", {31'b0, ys}, {31'b0, mon_e.src});
          check("beat_ready", {31'b0, mon_e.src ? br : ar}, 32'd1);
        end
      end
    end
  end

  task automatic drive();
    a_valid = a_q.size() > 0;
    a_data  = a_valid ? a_q[0] : 8'h00;
    b_valid = b_q.size() > 0;
    b_data  = b_valid ? b_q[0] : 8'h00;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      logic acc_a, acc_b;
      @(negedge clk);
      acc_a = a_valid & ar;
      acc_b = b_valid & br;
      @(posedge clk);
      #1;
      if (acc_a && a_q.size() > 0) void'(a_q.pop_front());
      if (acc_b && b_q.size() > 0) void'(b_q.pop_front());
      drive();
    end
  endtask

  task automatic ex(input logic s, input logic [7:0] d);
    exp_q.push_back({s, d});
  endtask

  task automatic reset_dut(input logic which);
    rst_n = 1'b0;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    y_ready = 1'b1;
    drive();
    dsel = which;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic done(input string name, input int from, input int want);
    check({name, "_beats"}, beats - from, want);
    check({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // reset state
    reset_dut(1'b0);
    check("rst_y_valid", {31'b0, yv}, 32'd0);
    check("rst_a_ready", {31'b0, ar}, 32'd0);
    check("rst_b_ready", {31'b0, br}, 32'd0);
    check("rst_sel", {31'b0, ys}, 32'd0);

    // A alone, 6 beats straight through the burst boundary
    b0 = beats;
    for (int i = 0; i < 6; i++) begin
      a_q.push_back(8'h10 + 8'(i));
      ex(1'b0, 8'h10 + 8'(i));
    end
    drive();
    cyc(1);
    check("t1_sel", {31'b0, ys}, 32'd0);
    cyc(6);
    done("t1", b0, 6);
    cyc(2);
    check("t1_idle_valid", {31'b0, yv}, 32'd0);
    check("t1_idle_sel", {31'b0, ys}, 32'd0);

    // both valid: A x4, B x4, A x4
    reset_dut(1'b0);
    b0 = beats;
    for (int i = 0; i < 8; i++) a_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) b_q.push_back(8'hB0 + 8'(i));
    for (int i = 0; i < 4; i++) ex(1'b0, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) ex(1'b1, 8'hB0 + 8'(i));
    for (int i = 4; i < 8; i++) ex(1'b0, 8'hA0 + 8'(i));
    drive();
    cyc(5);
    check("t2_switch_sel", {31'b0, ys}, 32'd1);
    cyc(8);
    done("t2", b0, 12);

    // MAX_BURST=1: strict alternation
    reset_dut(1'b1);
    b0 = beats;
    for (int i = 0; i < 4; i++) begin
      a_q.push_back(8'h30 + 8'(i));
      b_q.push_back(8'h40 + 8'(i));
      ex(1'b0, 8'h30 + 8'(i));
      ex(1'b1, 8'h40 + 8'(i));
    end
    drive();
    cyc(9);
    done("t3", b0, 8);

    // sink stall mid-burst on A with B waiting
    reset_dut(1'b0);
    b0 = beats;
    for (int i = 0; i < 6; i++) a_q.push_back(8'h50 + 8'(i));
    b_q.push_back(8'h60);
    b_q.push_back(8'h61);
    ex(1'b0, 8'h50);
    ex(1'b0, 8'h51);
    ex(1'b0, 8'h52);
    ex(1'b0, 8'h53);
    ex(1'b1, 8'h60);
    ex(1'b1, 8'h61);
    ex(1'b0, 8'h54);
    ex(1'b0, 8'h55);
    drive();
    cyc(3);
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t4_stall_valid", {31'b0, yv}, 32'd1);
      check("t4_stall_data", {24'b0, yd}, 32'h52);
      check("t4_stall_sel", {31'b0, ys}, 32'd0);
    end
    check("t4_stall_beats", beats - b0, 32'd2);
    y_ready = 1'b1;
    cyc(7);
    done("t4", b0, 8);

    // A drops after 2 beats, B takes over
    reset_dut(1'b0);
    b0 = beats;
    a_q.push_back(8'h70);
    a_q.push_back(8'h71);
    for (int i = 0; i < 3; i++) begin
      b_q.push_back(8'h80 + 8'(i));
    end
    ex(1'b0, 8'h70);
    ex(1'b0, 8'h71);
    for (int i = 0; i < 3; i++) ex(1'b1, 8'h80 + 8'(i));
    drive();
    cyc(4);
    check("t5_sel", {31'b0, ys}, 32'd1);
    check("t5_valid", {31'b0, yv}, 32'd1);
    check("t5_data", {24'b0, yd}, 32'h80);
    cyc(3);
    done("t5", b0, 5);

    // async reset during beat 2 of a B burst
    reset_dut(1'b0);
    b0 = beats;
    for (int i = 0; i < 4; i++) b_q.push_back(8'h90 + 8'(i));
    ex(1'b1, 8'h90);
    drive();
    cyc(2);
    check("t6_pre_valid", {31'b0, yv}, 32'd1);
    check("t6_pre_sel", {31'b0, ys}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_y_valid", {31'b0, yv}, 32'd0);
    check("t6_rst_a_ready", {31'b0, ar}, 32'd0);
    check("t6_rst_b_ready", {31'b0, br}, 32'd0);
    check("t6_rst_sel", {31'b0, ys}, 32'd0);
    done("t6", b0, 1);
    reset_dut(1'b0);
    b0 = beats;
    a_q.push_back(8'hC0);
    b_q.push_back(8'hD0);
    ex(1'b0, 8'hC0);
    ex(1'b1, 8'hD0);
    drive();
    cyc(1);
    check("t6_tie_sel", {31'b0, ys}, 32'd0);
    cyc(3);
    done("t6b", b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
